bit_tx_sequencer: RTL

//  Frame-level TX controller that sequences the bit-rate tick generator for one frame.
//  - Latches rate_sel at frame start and drives the generator's enable/rate_sel.
//  - Pulls payload bytes over a valid/ready stream; shifts them out MSB-first, one bit per bit_tick.
//  - Sits between the PL packet source and the line serializer / modulator in the clk_130M domain.

---
 rtl/bit_tx_sequencer.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/bit_tx_sequencer.sv
// Frame-level TX sequencer: preamble, MSB-first payload via a 1-byte hold buffer, tick generator control.
// Define BIT_TX_SEQ_CRC8_EN to append a CRC-8 (poly 0x07, init 0x00) trailer after the payload.

module bit_tx_sequencer #(
  parameter int PRE_BITS = 8,
  parameter int LEN_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       rate_sel_in,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             abort,
  output logic             tick_en,
  output logic [2:0]       tick_rate_sel,
  input  logic             bit_tick,
  input  logic [7:0]       byte_data,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             tx_bit,
  output logic             tx_bit_stb,
  output logic             busy,
  output logic             done,
  output logic             underrun
);

`ifdef BIT_TX_SEQ_CRC8_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PRE = 2'd1, S_DATA = 2'd2, S_CRC = 2'd3} state_t;

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[7] ^ data[i]) c = {c[6:0], 1'b0} ^ 8'h07;
      else                c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  logic [7:0] crc_q, crc_d;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PRE = 2'd1, S_DATA = 2'd2} state_t;
`endif

  state_t           state_q, state_d;
  logic [2:0]       rate_q, rate_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] fetched_q, fetched_d;
  logic [LEN_W-1:0] loaded_q, loaded_d;
  logic [7:0]       pre_cnt_q, pre_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_vld_q, hold_vld_d;
  logic             fin_q, fin_d;
  logic             busy_q, busy_d;
  logic             tx_bit_q, tx_bit_d;
  logic             stb_q, stb_d;
  logic             done_q, done_d;
  logic             und_q, und_d;

  // Byte stream: a byte transfers on any cycle with byte_valid && byte_ready.
  // byte_ready depends only on registered state, never on byte_valid.
  logic       hs;
  logic       byte_avail;
  logic [7:0] next_byte;

  assign byte_ready = busy_q && !hold_vld_q && (fetched_q < len_q);
  assign hs         = byte_valid && byte_ready;
  assign byte_avail = hold_vld_q || hs;
  assign next_byte  = hold_vld_q ? hold_q : byte_data;

  always_comb begin
    state_d    = state_q;
    rate_d     = rate_q;
    len_d      = len_q;
    fetched_d  = fetched_q;
    loaded_d   = loaded_q;
    pre_cnt_d  = pre_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    fin_d      = fin_q;
    busy_d     = busy_q;
    tx_bit_d   = tx_bit_q;
    stb_d      = 1'b0;
    done_d     = 1'b0;
    und_d      = 1'b0;
`ifdef BIT_TX_SEQ_CRC8_EN
    crc_d      = crc_q;
`endif

    if (hs) begin
      fetched_d  = fetched_q + LEN_W'(1);
      hold_d     = byte_data;
      hold_vld_d = 1'b1;
    end

    // fin_q marks the cycle after the final bit: done pulses with busy dropping.
    if (fin_q) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      fin_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start && (frame_len != '0)) begin
            state_d    = S_PRE;
            rate_d     = rate_sel_in;
            len_d      = frame_len;
            fetched_d  = '0;
            loaded_d   = '0;
            pre_cnt_d  = 8'd0;
            bit_cnt_d  = 3'd0;
            hold_vld_d = 1'b0;
            busy_d     = 1'b1;
`ifdef BIT_TX_SEQ_CRC8_EN
            crc_d      = 8'h00;
`endif
          end
        end
        S_PRE: begin
          if (bit_tick) begin
            tx_bit_d  = ~pre_cnt_q[0];
            stb_d     = 1'b1;
            pre_cnt_d = pre_cnt_q + 8'd1;
            if (pre_cnt_q == 8'(PRE_BITS - 1)) state_d = S_DATA;
          end
        end
        S_DATA: begin
          if (bit_tick) begin
            if (bit_cnt_q == 3'd0) begin
              // Shifter empty: this tick needs a byte from the buffer or the bypass path.
              if (byte_avail) begin
                tx_bit_d   = next_byte[7];
                shift_d    = {next_byte[6:0], 1'b0};
                bit_cnt_d  = 3'd7;
                loaded_d   = loaded_q + LEN_W'(1);
                hold_vld_d = 1'b0;
                stb_d      = 1'b1;
`ifdef BIT_TX_SEQ_CRC8_EN
                crc_d      = crc8_byte(crc_q, next_byte);
`endif
              end else begin
                und_d   = 1'b1;
                state_d = S_IDLE;
                busy_d  = 1'b0;
              end
            end else begin
              tx_bit_d  = shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q - 3'd1;
              stb_d     = 1'b1;
              if ((bit_cnt_q == 3'd1) && (loaded_q == len_q)) begin
`ifdef BIT_TX_SEQ_CRC8_EN
                state_d   = S_CRC;
                shift_d   = crc_q;
                bit_cnt_d = 3'd0;
`else
                fin_d     = 1'b1;
`endif
              end
            end
          end
        end
`ifdef BIT_TX_SEQ_CRC8_EN
        S_CRC: begin
          if (bit_tick) begin
            tx_bit_d  = shift_q[7];
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 3'd1;
            stb_d     = 1'b1;
            if (bit_cnt_q == 3'd7) fin_d = 1'b1;
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end

    if (abort) begin
      state_d    = S_IDLE;
      busy_d     = 1'b0;
      fin_d      = 1'b0;
      hold_vld_d = 1'b0;
      tx_bit_d   = tx_bit_q;
      stb_d      = 1'b0;
      done_d     = 1'b0;
      und_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rate_q     <= 3'd0;
      len_q      <= '0;
      fetched_q  <= '0;
      loaded_q   <= '0;
      pre_cnt_q  <= 8'd0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      hold_q     <= 8'h00;
      hold_vld_q <= 1'b0;
      fin_q      <= 1'b0;
      busy_q     <= 1'b0;
      tx_bit_q   <= 1'b0;
      stb_q      <= 1'b0;
      done_q     <= 1'b0;
      und_q      <= 1'b0;
`ifdef BIT_TX_SEQ_CRC8_EN
      crc_q      <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      rate_q     <= rate_d;
      len_q      <= len_d;
      fetched_q  <= fetched_d;
      loaded_q   <= loaded_d;
      pre_cnt_q  <= pre_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      fin_q      <= fin_d;
      busy_q     <= busy_d;
      tx_bit_q   <= tx_bit_d;
      stb_q      <= stb_d;
      done_q     <= done_d;
      und_q      <= und_d;
`ifdef BIT_TX_SEQ_CRC8_EN
      crc_q      <= crc_d;
`endif
    end
  end

  assign tick_en       = busy_q;
  assign busy          = busy_q;
  assign tick_rate_sel = rate_q;
  assign tx_bit        = tx_bit_q;
  assign tx_bit_stb    = stb_q;
  assign done          = done_q;
  assign underrun      = und_q;

endmodule
